planificador_demux: RTL and testbench

Round-robin scheduler that feeds the 8-channel byte demultiplexer. It accepts a byte stream from one upstream producer through a one-entry holding buffer. It chooses a destination channel among those enabled and ready, then drives the demultiplexer's `sel`/data inputs with a one-hot delivery strobe. Bytes that wait too long with no eligible channel are discarded and counted.

---
 rtl/planificador_demux.sv | 170 +++++++++++++++++
 tb/tb_planificador_demux.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/planificador_demux.sv
// planificador_demux: round-robin scheduler in front of the 8-channel byte
// demultiplexer. A one-entry holding buffer takes bytes from the producer.
// Each byte is steered to an eligible channel (enabled and ready), either by
// round-robin from a rotating pointer or to a fixed channel. A byte that waits
// LIMITE edges with no eligible channel is discarded and counted.
module planificador_demux #(
  parameter int LIMITE = 16  // legal range 1..255
) (
  input  logic        reloj,
  input  logic        reset,
  input  logic [7:0]  dato_in,
  input  logic        valido_in,
  output logic        listo_out,
  input  logic [7:0]  listo_canal,
  input  logic [7:0]  habilitado,
  input  logic        modo_fijo,
  input  logic [2:0]  canal_fijo,
  output logic [2:0]  sel,
  output logic [7:0]  dato_out,
  output logic [7:0]  valido_out,
  output logic        descartado,
  output logic [15:0] cuenta_ok,
  output logic [7:0]  cuenta_desc
);

  // Wait-counter value at which a stalled byte is given up on.
  localparam logic [7:0] LIMITE_M1 = 8'(LIMITE - 1);

  // Holding buffer, pointer and wait counter.
  logic [7:0]  buf_q, buf_d;
  logic        lleno_q, lleno_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [7:0]  espera_q, espera_d;

  // Registered outputs toward the demultiplexer and the status counters.
  logic [2:0]  sel_q, sel_d;
  logic [7:0]  dato_out_q, dato_out_d;
  logic [7:0]  valido_out_q, valido_out_d;
  logic        descartado_q, descartado_d;
  logic [15:0] cuenta_ok_q, cuenta_ok_d;
  logic [7:0]  cuenta_desc_q, cuenta_desc_d;

  // Combinational channel selection.
  logic [7:0]  elegible_s;
  logic        encontrado_s;
  logic [2:0]  canal_s;
  logic [2:0]  idx_s;
  logic        vence_s;
  logic        acepta_s;

  // Pick the destination channel: fixed channel if eligible, else the first
  // eligible channel at or after the round-robin pointer.
  always_comb begin
    elegible_s   = habilitado & listo_canal;
    encontrado_s = 1'b0;
    canal_s      = 3'd0;
    idx_s        = 3'd0;
    if (modo_fijo) begin
      if (elegible_s[canal_fijo]) begin
        encontrado_s = 1'b1;
        canal_s      = canal_fijo;
      end else begin
        encontrado_s = 1'b0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        idx_s = ptr_q + 3'(i);
        if (!encontrado_s && elegible_s[idx_s]) begin
          encontrado_s = 1'b1;
          canal_s      = idx_s;
        end else begin
          encontrado_s = encontrado_s;
        end
      end
    end
  end

  // Drop condition and producer handshake; a delivery or a drop frees the
  // buffer on the same edge, so a new byte can be taken back-to-back.
  always_comb begin
    vence_s   = lleno_q & ~encontrado_s & (espera_q == LIMITE_M1);
    listo_out = ~lleno_q | encontrado_s | vence_s;
    acepta_s  = valido_in & listo_out;
  end

  // Next-state logic: deliver, wait or drop the buffered byte, then accept.
  always_comb begin
    buf_d         = buf_q;
    lleno_d       = lleno_q;
    ptr_d         = ptr_q;
    espera_d      = espera_q;
    sel_d         = sel_q;
    dato_out_d    = dato_out_q;
    valido_out_d  = 8'h00;
    descartado_d  = 1'b0;
    cuenta_ok_d   = cuenta_ok_q;
    cuenta_desc_d = cuenta_desc_q;

    if (lleno_q && encontrado_s) begin
      sel_d        = canal_s;
      dato_out_d   = buf_q;
      valido_out_d = 8'h01 << canal_s;
      lleno_d      = 1'b0;
      espera_d     = 8'd0;
      cuenta_ok_d  = cuenta_ok_q + 16'd1;
      if (!modo_fijo) begin
        ptr_d = canal_s + 3'd1;
      end else begin
        ptr_d = ptr_q;
      end
    end else if (lleno_q) begin
      if (vence_s) begin
        lleno_d      = 1'b0;
        espera_d     = 8'd0;
        descartado_d = 1'b1;
        if (cuenta_desc_q != 8'hFF) begin
          cuenta_desc_d = cuenta_desc_q + 8'd1;
        end else begin
          cuenta_desc_d = cuenta_desc_q;
        end
      end else begin
        espera_d = espera_q + 8'd1;
      end
    end else begin
      espera_d = 8'd0;
    end

    if (acepta_s) begin
      buf_d   = dato_in;
      lleno_d = 1'b1;
    end else begin
      buf_d = buf_d;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      buf_q         <= 8'h00;
      lleno_q       <= 1'b0;
      ptr_q         <= 3'd0;
      espera_q      <= 8'd0;
      sel_q         <= 3'd0;
      dato_out_q    <= 8'h00;
      valido_out_q  <= 8'h00;
      descartado_q  <= 1'b0;
      cuenta_ok_q   <= 16'h0000;
      cuenta_desc_q <= 8'h00;
    end else begin
      buf_q         <= buf_d;
      lleno_q       <= lleno_d;
      ptr_q         <= ptr_d;
      espera_q      <= espera_d;
      sel_q         <= sel_d;
      dato_out_q    <= dato_out_d;
      valido_out_q  <= valido_out_d;
      descartado_q  <= descartado_d;
      cuenta_ok_q   <= cuenta_ok_d;
      cuenta_desc_q <= cuenta_desc_d;
    end
  end

  assign sel         = sel_q;
  assign dato_out    = dato_out_q;
  assign valido_out  = valido_out_q;
  assign descartado  = descartado_q;
  assign cuenta_ok   = cuenta_ok_q;
  assign cuenta_desc = cuenta_desc_q;

endmodule

// File: tb/tb_planificador_demux.sv
// Directed testbench for planificador_demux. Two instances share the stimulus:
// u16 (LIMITE=16) for delivery, fixed mode, reset and wrap checks, and
// u4 (LIMITE=4) for discard timing and counter saturation.
module tb_planificador_demux;

  logic        reloj;
  logic        reset;
  logic [7:0]  dato_in;
  logic        valido_in;
  logic [7:0]  listo_canal;
  logic [7:0]  habilitado;
  logic        modo_fijo;
  logic [2:0]  canal_fijo;

  logic        u16_listo_out, u4_listo_out;
  logic [2:0]  u16_sel, u4_sel;
  logic [7:0]  u16_dato_out, u4_dato_out;
  logic [7:0]  u16_valido_out, u4_valido_out;
  logic        u16_descartado, u4_descartado;
  logic [15:0] u16_cuenta_ok, u4_cuenta_ok;
  logic [7:0]  u16_cuenta_desc, u4_cuenta_desc;

  int n_asserts = 0;
  int n_fail    = 0;

  planificador_demux #(.LIMITE(16)) u16 (
    .reloj(reloj), .reset(reset), .dato_in(dato_in), .valido_in(valido_in),
    .listo_out(u16_listo_out), .listo_canal(listo_canal), .habilitado(habilitado),
    .modo_fijo(modo_fijo), .canal_fijo(canal_fijo), .sel(u16_sel),
    .dato_out(u16_dato_out), .valido_out(u16_valido_out),
    .descartado(u16_descartado), .cuenta_ok(u16_cuenta_ok),
    .cuenta_desc(u16_cuenta_desc)
  );

  planificador_demux #(.LIMITE(4)) u4 (
    .reloj(reloj), .reset(reset), .dato_in(dato_in), .valido_in(valido_in),
    .listo_out(u4_listo_out), .listo_canal(listo_canal), .habilitado(habilitado),
    .modo_fijo(modo_fijo), .canal_fijo(canal_fijo), .sel(u4_sel),
    .dato_out(u4_dato_out), .valido_out(u4_valido_out),
    .descartado(u4_descartado), .cuenta_ok(u4_cuenta_ok),
    .cuenta_desc(u4_cuenta_desc)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    reloj = 1'b0;
    forever #5 reloj = ~reloj;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stream n bytes base, base+1, ... at full rate into u16; byte j must come
  // out on channel sels[3j+:3] two negedges after it was driven.
  task automatic run_stream(input int n, input logic [7:0] base, input logic [23:0] sels);
    logic [2:0] k;
    for (int i = 0; i < n + 3; i++) begin
      @(negedge reloj);
      if (i >= 2 && i < n + 2) begin
        k = sels[3*(i-2) +: 3];
        check("strm_vld", 32'(u16_valido_out), 32'(8'(8'd1 << k)));
        check("strm_sel", 32'(u16_sel), 32'(k));
        check("strm_dat", 32'(u16_dato_out), 32'(base + 8'(i - 2)));
      end else if (i == n + 2) begin
        check("strm_idle", 32'(u16_valido_out), 32'd0);
      end
      if (i < n) begin
        valido_in = 1'b1;
        dato_in   = base + 8'(i);
      end else begin
        valido_in = 1'b0;
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    dato_in     = 8'h00;
    valido_in   = 1'b0;
    listo_canal = 8'hFF;
    habilitado  = 8'hFF;
    modo_fijo   = 1'b0;
    canal_fijo  = 3'd0;

    // Reset state.
    repeat (2) @(negedge reloj);
    #1;
    check("rst_sel", 32'(u16_sel), 32'd0);
    check("rst_dat", 32'(u16_dato_out), 32'd0);
    check("rst_vld", 32'(u16_valido_out), 32'd0);
    check("rst_desc", 32'(u16_descartado), 32'd0);
    check("rst_cok", 32'(u16_cuenta_ok), 32'd0);
    check("rst_cdesc", 32'(u16_cuenta_desc), 32'd0);
    check("rst_listo", 32'(u16_listo_out), 32'd1);
    reset = 1'b0;

    // Full-rate round robin over all 8 channels.
    run_stream(8, 8'h10, 24'hFAC688);
    check("rr8_cok", 32'(u16_cuenta_ok), 32'd8);

    // Only channels 2 and 5 enabled: 2,5,2,5, leaving the pointer at 6.
    habilitado = 8'h24;
    run_stream(4, 8'h20, 24'h000AAA);
    check("ch25_cok", 32'(u16_cuenta_ok), 32'd12);
    habilitado = 8'hFF;
    run_stream(1, 8'h30, 24'd6);

    // Fixed mode to channel 3 while consumer 3 is busy, then ready.
    modo_fijo   = 1'b1;
    canal_fijo  = 3'd3;
    listo_canal = 8'hF7;
    valido_in   = 1'b1;
    dato_in     = 8'h33;
    #1;
    check("fix_listo_empty", 32'(u16_listo_out), 32'd1);
    @(negedge reloj);
    valido_in = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #1;
      check("fix_listo_wait", 32'(u16_listo_out), 32'd0);
      check("fix_vld_wait", 32'(u16_valido_out), 32'd0);
      @(negedge reloj);
    end
    listo_canal = 8'hFF;
    #1;
    check("fix_listo_rdy", 32'(u16_listo_out), 32'd1);
    @(negedge reloj);
    check("fix_vld", 32'(u16_valido_out), 32'h08);
    check("fix_sel", 32'(u16_sel), 32'd3);
    check("fix_dat", 32'(u16_dato_out), 32'h33);
    check("fix_desc", 32'(u16_descartado), 32'd0);
    check("fix_cok", 32'(u16_cuenta_ok), 32'd14);
    modo_fijo = 1'b0;

    // Pointer from 7 to channel 4 leaves it at 5; buffer a byte, then reset.
    habilitado = 8'h10;
    run_stream(1, 8'h44, 24'd4);
    habilitado = 8'h00;
    valido_in  = 1'b1;
    dato_in    = 8'h66;
    @(negedge reloj);
    valido_in = 1'b0;
    reset     = 1'b1;
    #1;
    check("mrst_vld", 32'(u16_valido_out), 32'd0);
    check("mrst_sel", 32'(u16_sel), 32'd0);
    check("mrst_dat", 32'(u16_dato_out), 32'd0);
    check("mrst_cok", 32'(u16_cuenta_ok), 32'd0);
    check("mrst_listo", 32'(u16_listo_out), 32'd1);
    @(negedge reloj);
    reset      = 1'b0;
    habilitado = 8'hFF;
    run_stream(1, 8'h55, 24'd0);
    check("mrst_cok_after", 32'(u16_cuenta_ok), 32'd1);

    // Discard on u4 (LIMITE=4): 0xAA accepted at edge N, dropped at N+4,
    // 0xBB taken on the drop edge.
    habilitado = 8'h00;
    valido_in  = 1'b1;
    dato_in    = 8'hAA;
    @(negedge reloj);
    valido_in = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check("drop_nodesc", 32'(u4_descartado), 32'd0);
      @(negedge reloj);
    end
    valido_in = 1'b1;
    dato_in   = 8'hBB;
    #1;
    check("drop_listo", 32'(u4_listo_out), 32'd1);
    @(negedge reloj);
    check("drop_pulse", 32'(u4_descartado), 32'd1);
    check("drop_cdesc", 32'(u4_cuenta_desc), 32'd1);
    check("drop_vld", 32'(u4_valido_out), 32'd0);
    valido_in = 1'b0;
    #1;
    check("drop_held", 32'(u4_listo_out), 32'd0);
    habilitado = 8'hFF;
    @(negedge reloj);
    check("drop_new_dat", 32'(u4_dato_out), 32'hBB);
    check("drop_new_vld", 32'(u4_valido_out), 32'h02);
    check("drop_new_desc", 32'(u4_descartado), 32'd0);

    // Sustained drops saturate the discard counter.
    habilitado = 8'h00;
    valido_in  = 1'b1;
    dato_in    = 8'hC0;
    repeat (1210) @(negedge reloj);
    check("sat_cdesc", 32'(u4_cuenta_desc), 32'd255);
    valido_in  = 1'b0;
    habilitado = 8'hFF;
    repeat (3) @(negedge reloj);

    // Delivered-byte counter wraps after 65536 deliveries.
    reset = 1'b1;
    @(negedge reloj);
    reset     = 1'b0;
    valido_in = 1'b1;
    dato_in   = 8'h01;
    repeat (65535) @(negedge reloj);
    valido_in = 1'b0;
    repeat (3) @(negedge reloj);
    check("wrap_ffff", 32'(u16_cuenta_ok), 32'h0000FFFF);
    run_stream(1, 8'h77, 24'd7);
    check("wrap_zero", 32'(u16_cuenta_ok), 32'h00000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
